// File: rtl/prox_fpga_core.sv
// prox_fpga_core: RF front-end controller running on the 13.56 MHz carrier.
//   A host writes 16-bit config words over a write-only SPI port; the word
//   selects a major mode (conf[7:5]) and an LF divisor. The core then drives
//   the antenna controls, clocks and samples the ADC, and streams the samples
//   back over a framed SSP link.
// Ports:
//   ck_1356meg, nreset          clock, synchronous active-low reset
//   spcki, mosi, ncs, miso      host SPI (async inputs, registered readback)
//   adc_d, adc_clk, adc_noe     ADC sample bus, conversion clock, output enable
//   pwr_lo/hi, pwr_oe1..4       antenna driver controls
//   ssp_frame/din/clk, ssp_dout sample stream to host, modulation from host
//   cross_hi, cross_lo, dbg     comparator inputs and debug observation
//   pck0i, ck_1356megb          reserved, ignored
module prox_fpga_core #(
  parameter logic [7:0] DIV_RST  = 8'h5F,
  parameter logic [7:0] CONF_RST = 8'hE0
) (
  input  logic       ck_1356meg,
  input  logic       nreset,
  input  logic       spcki,
  input  logic       mosi,
  input  logic       ncs,
  output logic       miso,
  input  logic       pck0i,
  input  logic       ck_1356megb,
  input  logic [7:0] adc_d,
  output logic       adc_clk,
  output logic       adc_noe,
  output logic       pwr_lo,
  output logic       pwr_hi,
  output logic       pwr_oe1,
  output logic       pwr_oe2,
  output logic       pwr_oe3,
  output logic       pwr_oe4,
  output logic       ssp_frame,
  output logic       ssp_din,
  output logic       ssp_clk,
  input  logic       ssp_dout,
  input  logic       cross_hi,
  input  logic       cross_lo,
  output logic       dbg
);

  // Synchronisers; the third stage on spcki/ncs is the edge-detect history.
  logic [2:0] spcki_q, ncs_q;
  logic [1:0] mosi_q, xhi_q, xlo_q;

  logic [15:0] shreg_q, shreg_d;
  logic [7:0]  conf_q, conf_d, div_q, div_d;
  logic [2:0]  major, major_q;
  logic [7:0]  adc_cnt_q, adc_cnt_d, reload;
  logic        adc_clk_q, adc_clk_d;
  logic [7:0]  sample_q, sample_d;
  logic [5:0]  ssp_cnt_q, ssp_cnt_d;
  logic [7:0]  buf_q, buf_d;
  logic        frame_d, din_d, sclk_d;
  logic        spi_rise, ncs_rise;
  logic        unused_ok;

  assign unused_ok = &{1'b0, pck0i, ck_1356megb};

  assign major  = conf_q[7:5];
  assign reload = (major == 3'd0) ? div_q : 8'd1;

  always_comb begin
    spi_rise = spcki_q[1] & ~spcki_q[2] & ~ncs_q[1];
    ncs_rise = ncs_q[1] & ~ncs_q[2];

    shreg_d = shreg_q;
    if (spi_rise) shreg_d = {shreg_q[14:0], mosi_q[1]};

    conf_d = conf_q;
    div_d  = div_q;
    if (ncs_rise) begin
      case (shreg_q[15:12])
        4'h1:    conf_d = shreg_q[7:0];
        4'h2:    div_d  = shreg_q[7:0];
        default: ;
      endcase
    end

    // ADC clock: down-counter reloads on terminal count and toggles the clock.
    adc_cnt_d = adc_cnt_q;
    adc_clk_d = adc_clk_q;
    sample_d  = sample_q;
    if (major != major_q) begin
      adc_cnt_d = reload;
      adc_clk_d = 1'b0;
    end else if (major[2]) begin
      adc_cnt_d = 8'd0;
      adc_clk_d = 1'b0;
    end else if (adc_cnt_q == 8'd0) begin
      adc_cnt_d = reload;
      adc_clk_d = ~adc_clk_q;
      if (!adc_clk_q) sample_d = adc_d;
    end else begin
      adc_cnt_d = adc_cnt_q - 8'd1;
    end

    // SSP: counter bits [2:0] are the phase within a bit, [5:3] the bit index.
    ssp_cnt_d = 6'd0;
    frame_d   = 1'b0;
    sclk_d    = 1'b0;
    din_d     = 1'b0;
    buf_d     = 8'd0;
    if (!major[2]) begin
      ssp_cnt_d = ssp_cnt_q + 6'd1;
      frame_d   = (ssp_cnt_q[5:3] == 3'd0);
      sclk_d    = ssp_cnt_q[2];
      din_d     = ssp_din;
      buf_d     = buf_q;
      if (ssp_cnt_q[2:0] == 3'd0) begin
        if (ssp_cnt_q[5:3] == 3'd0) begin
          din_d = sample_q[7];
          buf_d = {sample_q[6:0], 1'b0};
        end else begin
          din_d = buf_q[7];
          buf_d = {buf_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (!nreset) begin
      spcki_q   <= 3'b000;
      ncs_q     <= 3'b111;  // idle-high history avoids a false commit on exit
      mosi_q    <= 2'b00;
      xhi_q     <= 2'b00;
      xlo_q     <= 2'b00;
      shreg_q   <= 16'd0;
      conf_q    <= CONF_RST;
      div_q     <= DIV_RST;
      major_q   <= CONF_RST[7:5];
      adc_cnt_q <= 8'd0;
      adc_clk_q <= 1'b0;
      sample_q  <= 8'd0;
      ssp_cnt_q <= 6'd0;
      buf_q     <= 8'd0;
      miso      <= 1'b0;
      adc_clk   <= 1'b0;
      adc_noe   <= 1'b1;
      pwr_lo    <= 1'b0;
      pwr_hi    <= 1'b0;
      pwr_oe1   <= 1'b0;
      pwr_oe2   <= 1'b0;
      pwr_oe3   <= 1'b0;
      pwr_oe4   <= 1'b0;
      ssp_frame <= 1'b0;
      ssp_din   <= 1'b0;
      ssp_clk   <= 1'b0;
      dbg       <= 1'b0;
    end else begin
      spcki_q   <= {spcki_q[1:0], spcki};
      ncs_q     <= {ncs_q[1:0], ncs};
      mosi_q    <= {mosi_q[0], mosi};
      xhi_q     <= {xhi_q[0], cross_hi};
      xlo_q     <= {xlo_q[0], cross_lo};
      shreg_q   <= shreg_d;
      conf_q    <= conf_d;
      div_q     <= div_d;
      major_q   <= major;
      adc_cnt_q <= adc_cnt_d;
      adc_clk_q <= adc_clk_d;
      sample_q  <= sample_d;
      ssp_cnt_q <= ssp_cnt_d;
      buf_q     <= buf_d;
      miso      <= ~ncs_q[1] & shreg_q[15];
      adc_clk   <= adc_clk_d;
      adc_noe   <= major[2];
      // pwr_lo uses the next adc_clk value so both pins change together.
      pwr_lo    <= (major == 3'd0) & adc_clk_d;
      pwr_hi    <= (major == 3'd1);
      pwr_oe1   <= (major == 3'd1) & ssp_dout;
      pwr_oe2   <= (major == 3'd1) & ssp_dout;
      pwr_oe3   <= (major == 3'd1) & ssp_dout;
      pwr_oe4   <= (major == 3'd2) & ssp_dout;
      ssp_frame <= frame_d;
      ssp_din   <= din_d;
      ssp_clk   <= sclk_d;
      dbg       <= (major == 3'd0) ? xlo_q[1] : xhi_q[1];
    end
  end

endmodule

// File: tb/tb_prox_fpga_core.sv
// Directed bench for prox_fpga_core: SPI configuration, ADC clocking,
// SSP streaming, antenna control per major mode and reset behaviour.
module tb_prox_fpga_core;

  logic clk = 1'b0;
  logic nreset, spcki, mosi, ncs, miso;
  logic [7:0] adc_d;
  logic adc_clk, adc_noe, pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4;
  logic ssp_frame, ssp_din, ssp_clk, ssp_dout, cross_hi, cross_lo, dbg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prox_fpga_core dut (
    .ck_1356meg (clk),
    .nreset     (nreset),
    .spcki      (spcki),
    .mosi       (mosi),
    .ncs        (ncs),
    .miso       (miso),
    .pck0i      (1'b0),
    .ck_1356megb(1'b0),
    .adc_d      (adc_d),
    .adc_clk    (adc_clk),
    .adc_noe    (adc_noe),
    .pwr_lo     (pwr_lo),
    .pwr_hi     (pwr_hi),
    .pwr_oe1    (pwr_oe1),
    .pwr_oe2    (pwr_oe2),
    .pwr_oe3    (pwr_oe3),
    .pwr_oe4    (pwr_oe4),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .ssp_clk    (ssp_clk),
    .ssp_dout   (ssp_dout),
    .cross_hi   (cross_hi),
    .cross_lo   (cross_lo),
    .dbg        (dbg)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pwr_vec();
    return {pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4};
  endfunction

  task automatic spi_shift(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      mosi = w[i];
      repeat (5) @(negedge clk);
      spcki = 1'b1;
      repeat (5) @(negedge clk);
      spcki = 1'b0;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic spi_write(input logic [15:0] w, input logic [7:0] exp_conf,
                           input logic [7:0] exp_div);
    @(negedge clk);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    spi_shift(w);
    chk("miso_busy", miso, w[15]);
    ncs = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("conf", dut.conf_q, exp_conf);
    chk("divisor", dut.div_q, exp_div);
    chk("miso_idle", miso, 1'b0);
    @(negedge clk);
  endtask

  task automatic adc_period(input int exp);
    logic prev;
    int first, per;
    first = -1;
    per   = -1;
    prev  = adc_clk;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (!prev && adc_clk) begin
        if (first < 0) first = n;
        else begin
          per = n - first;
          break;
        end
      end
      prev = adc_clk;
    end
    chk("adc_period", per, exp);
  endtask

  task automatic adc_idle();
    int toggles;
    logic prev;
    toggles = 0;
    prev = adc_clk;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (adc_clk != prev) toggles++;
      prev = adc_clk;
    end
    chk("adc_idle_toggles", toggles, 0);
    chk("adc_idle_level", adc_clk, 1'b0);
  endtask

  task automatic ssp_capture(input logic [63:0] exp_din);
    logic prev, found;
    logic [63:0] fv, cv, dv;
    found = 1'b0;
    prev  = ssp_frame;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!prev && ssp_frame) begin
        found = 1'b1;
        break;
      end
      prev = ssp_frame;
    end
    chk("ssp_frame_found", found, 1'b1);
    for (int i = 0; i < 64; i++) begin
      fv[i] = ssp_frame;
      cv[i] = ssp_clk;
      dv[i] = ssp_din;
      @(negedge clk);
    end
    chk("ssp_frame", fv, 64'h0000_0000_0000_00FF);
    chk("ssp_clk", cv, 64'hF0F0_F0F0_F0F0_F0F0);
    chk("ssp_din", dv, exp_din);
    chk("ssp_frame_next", ssp_frame, 1'b1);
  endtask

  initial begin
    int bad;
    nreset = 1'b0; spcki = 1'b0; mosi = 1'b0; ncs = 1'b1;
    adc_d = 8'hAA; ssp_dout = 1'b0; cross_hi = 1'b0; cross_lo = 1'b0;

    // Reset
    repeat (5) @(negedge clk);
    chk("reset_outputs",
        {adc_clk, adc_noe, pwr_vec(), ssp_frame, ssp_din, ssp_clk, dbg, miso},
        13'b0_1_000000_000_0_0);
    chk("reset_conf", dut.conf_q, 8'hE0);
    chk("reset_div", dut.div_q, 8'h5F);
    nreset = 1'b1;
    adc_idle();
    chk("idle_noe", adc_noe, 1'b1);

    // Major 3 (snoop), minor 3
    spi_write(16'h1063, 8'h63, 8'h5F);
    chk("m3_minor", dut.conf_q[4:0], 5'h03);
    chk("m3_noe", adc_noe, 1'b0);
    chk("m3_pwr", pwr_vec(), 6'b000000);
    adc_period(4);

    // SSP stream of two different sample values
    repeat (80) @(negedge clk);
    ssp_capture(64'h00FF_00FF_00FF_00FF);
    adc_d = 8'h3C;
    repeat (70) @(negedge clk);
    ssp_capture(64'h0000_FFFF_FFFF_0000);
    adc_d = 8'hAA;

    // LF mode with divisor 4
    spi_write(16'h2004, 8'h63, 8'h04);
    spi_write(16'h1000, 8'h00, 8'h04);
    adc_period(10);
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (pwr_lo !== adc_clk || pwr_vec() & 6'b011111) bad++;
    end
    chk("m0_pwr_follow", bad, 0);
    cross_lo = 1'b1;
    repeat (4) @(negedge clk);
    chk("m0_dbg_lo", dbg, 1'b1);
    cross_lo = 1'b0;
    repeat (4) @(negedge clk);
    chk("m0_dbg_lo_clr", dbg, 1'b0);

    // Unknown opcodes leave everything unchanged
    spi_write(16'h3FFF, 8'h00, 8'h04);
    spi_write(16'hF0E0, 8'h00, 8'h04);
    adc_period(10);

    // Divisor 0 gives ck/2
    spi_write(16'h2000, 8'h00, 8'h00);
    adc_period(2);

    // Major 1 (HF reader)
    spi_write(16'h1020, 8'h20, 8'h00);
    ssp_dout = 1'b0;
    repeat (3) @(negedge clk);
    chk("m1_pwr_dout0", pwr_vec(), 6'b010000);
    ssp_dout = 1'b1;
    repeat (3) @(negedge clk);
    chk("m1_pwr_dout1", pwr_vec(), 6'b011110);
    cross_hi = 1'b1;
    repeat (4) @(negedge clk);
    chk("m1_dbg_hi", dbg, 1'b1);
    cross_hi = 1'b0;

    // Major 2 (HF simulate)
    spi_write(16'h1040, 8'h40, 8'h00);
    repeat (3) @(negedge clk);
    chk("m2_pwr_dout1", pwr_vec(), 6'b000001);
    ssp_dout = 1'b0;
    repeat (3) @(negedge clk);
    chk("m2_pwr_dout0", pwr_vec(), 6'b000000);

    // Major 4: everything idle
    spi_write(16'h1080, 8'h80, 8'h00);
    repeat (10) @(negedge clk);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ssp_frame || ssp_din || ssp_clk) bad++;
    end
    chk("m4_ssp_quiet", bad, 0);
    chk("m4_noe", adc_noe, 1'b1);
    adc_idle();

    // Reset while a complete word sits in the shift register with ncs low
    spi_write(16'h1063, 8'h63, 8'h00);
    @(negedge clk);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    spi_shift(16'h10A5);
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (5) @(negedge clk);
    ncs = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_mid_conf", dut.conf_q, 8'hE0);
    chk("rst_mid_div", dut.div_q, 8'h5F);
    chk("rst_mid_noe", adc_noe, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
